// File: rtl/vc_writeback_buffer_pkg.sv
// lc3b_types: shared lc3b line types and the writeback-buffer FSM states.
// Used by vc_writeback_buffer and vc_wb_cam.
package lc3b_types;

  typedef logic [127:0] lc3b_line;
  typedef logic [11:0]  lc3b_line_addr;

  typedef enum logic {
    VC_WB_IDLE,
    VC_WB_WRITE
  } vc_wb_state_t;

endpackage

// File: rtl/vc_wb_cam.sv
// Address match over the writeback FIFO entries. It returns any hit, the newest matching slot,
// and whether some entry other than the head matches.
module vc_wb_cam
  import lc3b_types::*;
#(
  parameter int DEPTH = 4
) (
  input  logic [DEPTH-1:0]         valid,
  input  lc3b_line_addr            addr [DEPTH],
  input  logic [$clog2(DEPTH)-1:0] head,
  input  logic [$clog2(DEPTH)-1:0] tail,
  input  lc3b_line_addr            key,
  output logic                     hit,
  output logic [$clog2(DEPTH)-1:0] hit_idx,
  output logic                     hit_excl_head
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] slot;

  // Walk the entries from oldest to newest so that the last match seen is the newest.
  // Every non-head entry is newer than the head, so an excluded-head hit also leaves hit_idx off the head.
  always_comb begin
    hit           = 1'b0;
    hit_idx       = '0;
    hit_excl_head = 1'b0;
    slot          = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      slot = tail - PW'(k);
      if (valid[slot] && (addr[slot] == key)) begin
        hit     = 1'b1;
        hit_idx = slot;
        if (slot != head) begin
          hit_excl_head = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/vc_writeback_buffer.sv
// Victim-cache writeback buffer. It queues dirty lines and drains them one at a time over the pmem write handshake.
// Define VC_WB_FWD_EN to build the lookup/forwarding port; otherwise lookup_hit and lookup_data are tied to 0.
module vc_writeback_buffer
  import lc3b_types::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wb_req,
  input  lc3b_line_addr              wb_address,
  input  lc3b_line                   wb_data,
  output logic                       wb_ready,
  input  lc3b_line_addr              lookup_address,
  output logic                       lookup_hit,
  output lc3b_line                   lookup_data,
  output logic                       pmem_write,
  output logic [15:0]                pmem_address,
  output lc3b_line                   pmem_wdata,
  input  logic                       pmem_resp,
  output logic                       wb_empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  vc_wb_state_t  state, state_next;
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count_q;
  logic [DEPTH-1:0] valid;
  lc3b_line_addr addr_mem [DEPTH];
  lc3b_line      data_mem [DEPTH];

  logic          coal_hit_unused;
  logic          coal_match;
  logic [PW-1:0] coal_idx;
  logic          push, push_new, pop;

  // The head is never a coalescing target: once it is at the front it may be on the bus.
  vc_wb_cam #(.DEPTH(DEPTH)) u_coal_cam (
    .valid         (valid),
    .addr          (addr_mem),
    .head          (head),
    .tail          (tail),
    .key           (wb_address),
    .hit           (coal_hit_unused),
    .hit_idx       (coal_idx),
    .hit_excl_head (coal_match)
  );

  assign wb_ready = (count_q < CW'(DEPTH)) | coal_match;
  assign push     = wb_req & wb_ready;
  assign push_new = push & ~coal_match;
  assign pop      = (state == VC_WB_WRITE) & pmem_resp;

  always_comb begin
    state_next = state;
    pmem_write = 1'b0;
    case (state)
      VC_WB_IDLE: begin
        if (count_q != '0) begin
          state_next = VC_WB_WRITE;
        end
      end
      VC_WB_WRITE: begin
        pmem_write = 1'b1;
        if (pmem_resp) begin
          state_next = VC_WB_IDLE;
        end
      end
      default: state_next = VC_WB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= VC_WB_IDLE;
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
      valid   <= '0;
    end else begin
      state <= state_next;
      if (push_new) begin
        valid[tail] <= 1'b1;
        tail        <= tail + PW'(1);
      end
      if (pop) begin
        valid[head] <= 1'b0;
        head        <= head + PW'(1);
      end
      case ({push_new, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Line storage carries no reset; the valid bits alone decide what is live.
  always_ff @(posedge clk) begin
    if (push_new) begin
      addr_mem[tail] <= wb_address;
      data_mem[tail] <= wb_data;
    end else if (push) begin
      data_mem[coal_idx] <= wb_data;
    end
  end

  assign pmem_address = {addr_mem[head], 4'b0000};
  assign pmem_wdata   = data_mem[head];
  assign wb_empty     = (count_q == '0) && (state == VC_WB_IDLE);
  assign count        = count_q;

`ifdef VC_WB_FWD_EN
  logic          lk_hit;
  logic          lk_excl_unused;
  logic [PW-1:0] lk_idx;

  vc_wb_cam #(.DEPTH(DEPTH)) u_lookup_cam (
    .valid         (valid),
    .addr          (addr_mem),
    .head          (head),
    .tail          (tail),
    .key           (lookup_address),
    .hit           (lk_hit),
    .hit_idx       (lk_idx),
    .hit_excl_head (lk_excl_unused)
  );

  assign lookup_hit  = lk_hit;
  assign lookup_data = lk_hit ? data_mem[lk_idx] : '0;
`else
  lc3b_line_addr lookup_address_unused;

  assign lookup_address_unused = lookup_address;
  assign lookup_hit            = 1'b0;
  assign lookup_data           = '0;
`endif

endmodule
